shake256_sponge_ctrl: RTL
=========================

# shake256_sponge_ctrl

- Sequences the `KECCAK_f` permutation core as a complete SHAKE256 sponge (rate 1088 bits = 17 lanes of 64 bits, capacity 512 bits).
- Accepts a message as a stream of 64-bit words, XORs them into the rate and applies SHAKE padding.
- Runs the permutation once per full block, then squeezes a requested number of 64-bit output lanes.
- Sits between the host streaming interface and one `KECCAK_f` instance, and owns its state register and run control.

## Interface
Parameters:
- `RATE_LANES`, 17: lanes per block; fixed for SHAKE256.
- `OUT_W`, 16: width of the output-length field.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a new message; accepted only in IDLE.
- `out_lanes` in `OUT_W`: number of 64-bit output lanes; latched on the accepted `start`.
- `in_valid` / `in_ready` in/out 1: input handshake.
- `in_data` in 64: message word; `in_data[63:56]` is the earliest byte.
- `in_last` in 1: final message word.
- `in_nbytes` in 4: valid bytes (0..8) in the final word, MSB-aligned; ignored unless `in_last`.
- `out_valid` / `out_ready` out/in 1: output handshake.
- `out_data` out 64: squeezed lane, same byte order as `in_data`.
- `out_last` out 1: marks the final output lane.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when a message completes.
- `f_S_in` out 1600: state presented to the core.
- `f_run` out 1: core run/enable.
  - Low loads `f_S_in`.
  - High runs rounds.
- `f_S_out` in 1600: core result.
- `f_done` in 1: core finished its 24 rounds.

## Operation
- State register `S[1599:0]`, zero on reset and on an accepted `start`. `f_S_in = S`.
- Lane i occupies `S[1599-64i -: 64]`. Byte b of the rate is `S[1599-8b -: 8]`.
- States: IDLE, ABSORB, PERM_A, PAD, PERM_S, SQUEEZE.
- IDLE: `in_ready=0`, `out_valid=0`. `start` -> ABSORB, lane index k=0, pad_pending=0.
- ABSORB: `in_ready=1`. Each accepted word XORs into lane k, then k++.
  - Non-last word with k=16: -> PERM_A.
  - Last word, with p = 8k + `in_nbytes`:
    - p<136: XOR 0x1F at byte p and 0x80 at byte 135 (0x9F if p=135) in the same update. -> PERM_A, marked final.
    - p=136: set pad_pending. -> PERM_A.
  - Bytes beyond `in_nbytes` in the final word are masked to zero before the XOR.
- PERM_A / PERM_S: `f_run=1`. On `f_done=1`, `S <= f_S_out` and `f_run` drops the next cycle.
  - Exit from PERM_A:
    - pad_pending -> PAD.
    - final -> SQUEEZE, or IDLE with `done` if `out_lanes`=0.
    - otherwise -> ABSORB with k=0.
  - Exit from PERM_S: -> SQUEEZE with k=0.
- PAD: one cycle with no input. XOR 0x1F at byte 0 and 0x80 at byte 135. Clear pad_pending. -> PERM_A, marked final.
- SQUEEZE: `out_valid=1`, `out_data` = lane k, a remaining-lanes counter counts down.
  - On handshake:
    - If the remaining count was 1: assert `out_last` on that word, pulse `done` the next cycle, -> IDLE.
    - Else if k=16: -> PERM_S.
    - Else k++.
- `start` outside IDLE is ignored. `in_valid` outside ABSORB is ignored.

## Timing
- Reset values: `in_ready=0`, `out_valid=0`, `out_last=0`, `busy=0`, `done=0`, `f_run=0`, `out_data=0`, S=0.
- One input word per cycle in ABSORB.
- PERM entry is the cycle after the last lane of the block is accepted.
- `f_run` is low for at least 1 cycle between consecutive permutations.
- Per-block cost is 17 + L + 1 cycles, where L is the core latency from `f_run` rise to `f_done`.
- The first output lane is valid the cycle after PERM_A exits.
- `out_data`, `out_last` and `out_valid` hold stable while `out_ready=0`.
- Reset mid-operation: the next cycle is in IDLE with reset values. Any in-flight permutation is abandoned via `f_run=0`.

## Configuration
- `SPONGE_XOF_EN` defined:
  - Unbounded squeeze: PERM_S runs after every 17 output lanes until `out_lanes` lanes are delivered.
  - Maximum `out_lanes` is 2^`OUT_W`-1.
- Not defined:
  - `out_lanes` is clamped to 17 at latch time.
  - PERM_S is never entered; `out_last` arrives on lane min(`out_lanes`,17).

## Test plan
- Empty message (one word, `in_last=1`, `in_nbytes=0`), `out_lanes=4`:
  - f_S_in at first PERM_A has byte 0 = 0x1F, byte 135 = 0x80, rest 0.
  - First `out_data` = 0x46B9DD2B0BA88D13; `out_last` on lane 4; `done` pulses.
- 136-byte message (17 full words, last with `in_nbytes=8`), `out_lanes=1`:
  - Exactly two PERM_A passes with one PAD cycle between them.
  - Output matches the SHAKE256 golden model.
- Partial final word: 3 bytes 0x616263 (`in_nbytes=3`), `out_lanes=2`:
  - 0x1F at byte 3.
  - First output = 0x483366601360A877 (SHAKE256("abc")).
- Backpressure: hold `out_ready=0` for 5 cycles mid-squeeze -> `out_data` unchanged, no lane skipped or duplicated.
- `out_lanes=20`:
  - With `SPONGE_XOF_EN`: one PERM_S after lane 17, `out_last` on lane 20.
  - Without: `out_last` on lane 17, no PERM_S.
- Assert `reset` during PERM_A:
  - Next cycle `busy=0`, `f_run=0`, S=0.
  - A subsequent empty-message run reproduces the first scenario's output.

Source files
------------

// File: rtl/shake256_sponge_ctrl.sv
// SHAKE256 sponge sequencer around one external KECCAK_f core: absorbs 64-bit words,
// applies SHAKE padding, drives the permutation and squeezes output lanes.
// Optional feature macro: SPONGE_XOF_EN (unbounded squeeze with extra permutations).
module shake256_sponge_ctrl #(
    parameter int RATE_LANES = 17,
    parameter int OUT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [OUT_W-1:0] out_lanes,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic             in_last,
    input  logic [3:0]       in_nbytes,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [1599:0]    f_S_in,
    output logic             f_run,
    input  logic [1599:0]    f_S_out,
    input  logic             f_done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ABSORB  = 3'd1,
        ST_PERM_A  = 3'd2,
        ST_PAD     = 3'd3,
        ST_PERM_S  = 3'd4,
        ST_SQUEEZE = 3'd5
    } state_t;

    localparam logic [4:0]       LAST_LANE  = 5'(RATE_LANES - 1);
    localparam logic [7:0]       RATE_BYTES = 8'(8 * RATE_LANES);
    localparam logic [OUT_W-1:0] LANE_CAP   = OUT_W'(RATE_LANES);
    localparam logic [OUT_W-1:0] ONE_LANE   = OUT_W'(1);

    // Keeps the first nbytes bytes (MSB side) of a word, clears the rest.
    function automatic logic [63:0] tail_mask(input logic [3:0] nbytes);
        logic [63:0] m;
        if (nbytes >= 4'd8) begin
            m = {64{1'b1}};
        end else begin
            m = ~({64{1'b1}} >> {nbytes[2:0], 3'b000});
        end
        return m;
    endfunction

    function automatic logic [1599:0] lane_place(input logic [63:0] w, input logic [4:0] k);
        return {w, 1536'd0} >> {k, 6'd0};
    endfunction

    function automatic logic [1599:0] byte_place(input logic [7:0] v, input logic [7:0] b);
        return {v, 1592'd0} >> {b, 3'd0};
    endfunction

    function automatic logic [63:0] lane_pick(input logic [1599:0] s, input logic [4:0] k);
        logic [1599:0] t;
        t = s << {k, 6'd0};
        return t[1599 -: 64];
    endfunction

    // Domain byte at position p and the closing bit at the end of the rate (0x9F when they meet).
    function automatic logic [1599:0] pad_bits(input logic [7:0] p);
        return byte_place(8'h1F, p) ^ byte_place(8'h80, RATE_BYTES - 8'd1);
    endfunction

    state_t             state_r, state_s;
    logic [1599:0]      s_r, s_s;
    logic [4:0]         k_r, k_s;
    logic               pad_pending_r, pad_pending_s;
    logic               final_r, final_s;
    logic [OUT_W-1:0]   remaining_r, remaining_s;
    logic               done_s;

    logic               in_ready_r, in_ready_s;
    logic               out_valid_r, out_valid_s;
    logic               out_last_r, out_last_s;
    logic [63:0]        out_data_r, out_data_s;
    logic               busy_r, busy_s;
    logic               done_r;
    logic               f_run_r, f_run_s;

    logic [3:0]         nb_s;
    logic [63:0]        word_s;
    logic [7:0]         pos_s;
    logic [OUT_W-1:0]   lanes_clamped_s;

    assign nb_s   = (in_nbytes > 4'd8) ? 4'd8 : in_nbytes;
    assign word_s = in_last ? (in_data & tail_mask(nb_s)) : in_data;
    assign pos_s  = {k_r, 3'b000} + {4'd0, nb_s};

`ifdef SPONGE_XOF_EN
    assign lanes_clamped_s = out_lanes;
`else
    assign lanes_clamped_s = (out_lanes > LANE_CAP) ? LANE_CAP : out_lanes;
`endif

    // State register, sponge datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            s_r           <= '0;
            k_r           <= 5'd0;
            pad_pending_r <= 1'b0;
            final_r       <= 1'b0;
            remaining_r   <= '0;
            in_ready_r    <= 1'b0;
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            out_data_r    <= 64'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            f_run_r       <= 1'b0;
        end else begin
            state_r       <= state_s;
            s_r           <= s_s;
            k_r           <= k_s;
            pad_pending_r <= pad_pending_s;
            final_r       <= final_s;
            remaining_r   <= remaining_s;
            in_ready_r    <= in_ready_s;
            out_valid_r   <= out_valid_s;
            out_last_r    <= out_last_s;
            out_data_r    <= out_data_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            f_run_r       <= f_run_s;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_s       = state_r;
        s_s           = s_r;
        k_s           = k_r;
        pad_pending_s = pad_pending_r;
        final_s       = final_r;
        remaining_s   = remaining_r;
        done_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s       = ST_ABSORB;
                    s_s           = '0;
                    k_s           = 5'd0;
                    pad_pending_s = 1'b0;
                    final_s       = 1'b0;
                    remaining_s   = lanes_clamped_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ABSORB: begin
                if (in_valid) begin
                    s_s = s_r ^ lane_place(word_s, k_r);
                    if (in_last) begin
                        state_s = ST_PERM_A;
                        // A block that ends exactly full needs a separate padding-only block.
                        if (pos_s == RATE_BYTES) begin
                            pad_pending_s = 1'b1;
                            final_s       = 1'b0;
                        end else begin
                            s_s     = s_s ^ pad_bits(pos_s);
                            final_s = 1'b1;
                        end
                    end else if (k_r == LAST_LANE) begin
                        state_s = ST_PERM_A;
                    end else begin
                        k_s = k_r + 5'd1;
                    end
                end else begin
                    state_s = ST_ABSORB;
                end
            end
            ST_PERM_A: begin
                if (f_done) begin
                    s_s = f_S_out;
                    k_s = 5'd0;
                    if (pad_pending_r) begin
                        state_s = ST_PAD;
                    end else if (final_r) begin
                        if (remaining_r == '0) begin
                            state_s = ST_IDLE;
                            done_s  = 1'b1;
                        end else begin
                            state_s = ST_SQUEEZE;
                        end
                    end else begin
                        state_s = ST_ABSORB;
                    end
                end else begin
                    state_s = ST_PERM_A;
                end
            end
            ST_PAD: begin
                s_s           = s_r ^ pad_bits(8'd0);
                pad_pending_s = 1'b0;
                final_s       = 1'b1;
                state_s       = ST_PERM_A;
            end
            ST_PERM_S: begin
                if (f_done) begin
                    s_s     = f_S_out;
                    k_s     = 5'd0;
                    state_s = ST_SQUEEZE;
                end else begin
                    state_s = ST_PERM_S;
                end
            end
            ST_SQUEEZE: begin
                if (out_ready) begin
                    remaining_s = remaining_r - ONE_LANE;
                    if (remaining_r == ONE_LANE) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
`ifdef SPONGE_XOF_EN
                    end else if (k_r == LAST_LANE) begin
                        state_s = ST_PERM_S;
`endif
                    end else begin
                        k_s = k_r + 5'd1;
                    end
                end else begin
                    state_s = ST_SQUEEZE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        in_ready_s  = (state_s == ST_ABSORB);
        out_valid_s = (state_s == ST_SQUEEZE);
        out_last_s  = out_valid_s && (remaining_s == ONE_LANE);
        out_data_s  = out_valid_s ? lane_pick(s_s, k_s) : 64'd0;
        busy_s      = (state_s != ST_IDLE);
        f_run_s     = (state_s == ST_PERM_A) || (state_s == ST_PERM_S);
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign f_run     = f_run_r;
    assign f_S_in    = s_r;

endmodule
